vote_collector: RTL and testbench

//  Sequential front end for the 4-voter majority decision. Collects one ballot per voter over a

---
 rtl/vote_collector_if.sv | 22 ++
 rtl/vote_collector.sv | 142 ++++++++++++++
 tb/tb_vote_collector.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vote_collector_if.sv
// Vote handshake bundle for vote_collector.
// The voter side (master) offers votes. The collector (slave) returns vote_ready.
interface vote_collector_if;
    logic       vote_valid;
    logic [1:0] vote_id;
    logic       vote_val;
    logic       vote_ready;

    modport master (
        output vote_valid,
        output vote_id,
        output vote_val,
        input  vote_ready
    );

    modport slave (
        input  vote_valid,
        input  vote_id,
        input  vote_val,
        output vote_ready
    );
endinterface

// File: rtl/vote_collector.sv
// vote_collector: collects one ballot per voter (4 voters) in a session and registers the
// one-hot {pass,tie,fail} majority decision.
// Optional feature macro: VOTE_TIMEOUT_EN. When it is defined, a session timer forces the
// session closed after TIMEOUT_CYC cycles in COLLECT. When it is undefined, a session only
// closes once all four voters have cast a vote.
module vote_collector #(
    parameter int TIMEOUT_CYC = 16,
    parameter int TMR_W       = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    vote_collector_if.slave        vote,
    output logic [3:0]             ballot,
    output logic [3:0]             cast_mask,
    output logic [2:0]             result,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   dup_err
);

    typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, DONE} state_t;

    state_t     state_reg;
    logic [3:0] ballot_reg;
    logic [3:0] cast_mask_reg;
    logic [2:0] result_reg;
    logic       result_valid_reg;
    logic       busy_reg;
    logic       dup_err_reg;
    logic       vote_ready_reg;

    logic [3:0] vote_sel;
    logic [3:0] ballot_next;
    logic [3:0] cast_mask_next;
    logic       accept;
    logic       dup_hit;
    logic       timeout_hit;
    logic [2:0] yes_cnt;

    // vote_ready is only ever high in COLLECT, so this also gates out votes in other states
    assign accept  = vote.vote_valid && vote_ready_reg;
    assign dup_hit = accept && ((vote_sel & cast_mask_reg) != 4'b0000);

    // Per-voter decode: a first vote records the value, a repeat vote leaves it unchanged
    for (genvar gi = 0; gi < 4; gi++) begin : g_voter
        assign vote_sel[gi]       = (vote.vote_id == 2'(gi));
        assign ballot_next[gi]    = (accept && vote_sel[gi] && !cast_mask_reg[gi])
                                    ? vote.vote_val : ballot_reg[gi];
        assign cast_mask_next[gi] = cast_mask_reg[gi] | (accept & vote_sel[gi]);
    end

    // Yes-vote count of the closed ballot; uncast voters are already 0
    always_comb begin
        yes_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            yes_cnt = yes_cnt + {2'b00, ballot_reg[i]};
        end
    end

`ifdef VOTE_TIMEOUT_EN
    logic [TMR_W-1:0] timer_reg;

    assign timeout_hit = (timer_reg == TMR_W'(TIMEOUT_CYC - 1));

    // Session timer: cleared when a session opens, counts every COLLECT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg <= '0;
        end else if ((state_reg == IDLE || state_reg == DONE) && start) begin
            timer_reg <= '0;
        end else if (state_reg == COLLECT) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Session FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            ballot_reg       <= 4'b0000;
            cast_mask_reg    <= 4'b0000;
            result_reg       <= 3'b000;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            dup_err_reg      <= 1'b0;
            vote_ready_reg   <= 1'b0;
        end else begin
            dup_err_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg        <= COLLECT;
                        ballot_reg       <= 4'b0000;
                        cast_mask_reg    <= 4'b0000;
                        result_reg       <= 3'b000;
                        result_valid_reg <= 1'b0;
                        busy_reg         <= 1'b1;
                        vote_ready_reg   <= 1'b1;
                    end
                end
                COLLECT: begin
                    ballot_reg    <= ballot_next;
                    cast_mask_reg <= cast_mask_next;
                    dup_err_reg   <= dup_hit;
                    // A vote landing in the timeout cycle is still captured above
                    if (cast_mask_next == 4'b1111 || timeout_hit) begin
                        state_reg      <= DECIDE;
                        vote_ready_reg <= 1'b0;
                    end
                end
                DECIDE: begin
                    state_reg        <= DONE;
                    busy_reg         <= 1'b0;
                    result_valid_reg <= 1'b1;
                    if (yes_cnt >= 3'd3) begin
                        result_reg <= 3'b100;
                    end else if (yes_cnt == 3'd2) begin
                        result_reg <= 3'b010;
                    end else begin
                        result_reg <= 3'b001;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign vote.vote_ready = vote_ready_reg;
    assign ballot          = ballot_reg;
    assign cast_mask       = cast_mask_reg;
    assign result          = result_reg;
    assign result_valid    = result_valid_reg;
    assign busy            = busy_reg;
    assign dup_err         = dup_err_reg;

endmodule

// File: tb/tb_vote_collector.sv
// Testbench for vote_collector: directed sessions with a scoreboard. Stimulus pushes the
// expected decision (and expected duplicate-vote pulses). A monitor pops and compares
// whenever result_valid rises or dup_err is seen.
module tb_vote_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] ballot;
    logic [3:0] cast_mask;
    logic [2:0] result;
    logic       result_valid;
    logic       busy;
    logic       dup_err;

    always #5 clk = ~clk;

    vote_collector_if vif();

    vote_collector dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .vote         (vif),
        .ballot       (ballot),
        .cast_mask    (cast_mask),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .dup_err      (dup_err)
    );

    typedef struct packed {
        logic [2:0] result;
        logic [3:0] ballot;
        logic [3:0] mask;
    } exp_t;

    exp_t       exp_q[$];
    string      name_q[$];
    logic [3:0] dup_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // Monitor: compares DUT-presented outputs against the scoreboard queues
    exp_t  mon_e;
    string mon_nm;
    logic  rv_prev = 1'b0;
    logic [3:0] mon_dup;

    always @(negedge clk) begin
        if (rst) begin
            rv_prev <= 1'b0;
        end else begin
            if (result_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_nm = name_q.pop_front();
                    check({mon_nm, "_result"}, 32'(result), 32'(mon_e.result));
                    check({mon_nm, "_ballot"}, 32'(ballot), 32'(mon_e.ballot));
                    check({mon_nm, "_mask"}, 32'(cast_mask), 32'(mon_e.mask));
                end
            end
            if (dup_err) begin
                if (dup_q.size() == 0) begin
                    check("unexpected_dup_err", 32'(dup_q.size()), 32'd1);
                end else begin
                    mon_dup = dup_q.pop_front();
                    check("dup_ballot", 32'(ballot), 32'(mon_dup));
                end
            end
            rv_prev <= result_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic cast(input logic [1:0] id, input logic v);
        vif.vote_valid = 1'b1;
        vif.vote_id    = id;
        vif.vote_val   = v;
        tick();
        vif.vote_valid = 1'b0;
    endtask

    task automatic expect_result(input string nm, input logic [2:0] r,
                                 input logic [3:0] b, input logic [3:0] m);
        exp_t e;
        e.result = r;
        e.ballot = b;
        e.mask   = m;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ballot"}, 32'(ballot), 32'd0);
        check({tag, "_mask"}, 32'(cast_mask), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_rvalid"}, 32'(result_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_dup"}, 32'(dup_err), 32'd0);
        check({tag, "_ready"}, 32'(vif.vote_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        rst            = 1'b1;
        start          = 1'b0;
        vif.vote_valid = 1'b0;
        vif.vote_id    = 2'd0;
        vif.vote_val   = 1'b0;
        repeat (2) tick();
        check_reset_outputs("por");
        rst = 1'b0;
        tick();

        // Vote in IDLE is ignored
        cast(2'd0, 1'b1);
        check("idle_vote_ignored_mask", 32'(cast_mask), 32'd0);

        // Async reset mid-session
        pulse_start();
        check("collect_busy", 32'(busy), 32'd1);
        check("collect_ready", 32'(vif.vote_ready), 32'd1);
        cast(2'd0, 1'b1);
        cast(2'd1, 1'b1);
        check("mid_ballot", 32'(ballot), 32'h3);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle_busy", 32'(busy), 32'd0);

        // Majority pass, with latency checks
        pulse_start();
        expect_result("pass", 3'b100, 4'b0111, 4'b1111);
        cast(2'd0, 1'b1);
        cast(2'd1, 1'b1);
        cast(2'd2, 1'b1);
        cast(2'd3, 1'b0);
        check("decide_busy", 32'(busy), 32'd1);
        check("decide_rvalid", 32'(result_valid), 32'd0);
        check("decide_ready", 32'(vif.vote_ready), 32'd0);
        tick();
        check("done_rvalid", 32'(result_valid), 32'd1);
        check("done_busy", 32'(busy), 32'd0);

        // Vote while in DONE is ignored, decision held
        cast(2'd1, 1'b0);
        check("done_hold_ballot", 32'(ballot), 32'h7);
        check("done_hold_result", 32'(result), 32'h4);

        // Restart from DONE clears; tie session
        pulse_start();
        check("restart_rvalid", 32'(result_valid), 32'd0);
        check("restart_ballot", 32'(ballot), 32'd0);
        check("restart_result", 32'(result), 32'd0);
        check("restart_mask", 32'(cast_mask), 32'd0);
        expect_result("tie", 3'b010, 4'b1010, 4'b1111);
        cast(2'd3, 1'b1);
        cast(2'd2, 1'b0);
        cast(2'd1, 1'b1);
        cast(2'd0, 1'b0);
        repeat (2) tick();

        // Duplicate vote from voter 2
        pulse_start();
        dup_q.push_back(4'b0100);
        expect_result("dup_fail", 3'b001, 4'b0100, 4'b1111);
        cast(2'd2, 1'b1);
        cast(2'd2, 1'b0);
        cast(2'd0, 1'b0);
        cast(2'd1, 1'b0);
        cast(2'd3, 1'b0);
        repeat (2) tick();

        // Only voter 0 votes
        pulse_start();
        cast(2'd0, 1'b1);
`ifdef VOTE_TIMEOUT_EN
        expect_result("timeout", 3'b001, 4'b0001, 4'b0001);
        cnt = 1;
        while (!result_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check("timeout_edges_to_rvalid", 32'(cnt), 32'd17);
`else
        repeat (20) tick();
        check("no_timeout_busy", 32'(busy), 32'd1);
        check("no_timeout_rvalid", 32'(result_valid), 32'd0);
        check("no_timeout_mask", 32'(cast_mask), 32'h1);
        expect_result("late_fill", 3'b001, 4'b0001, 4'b1111);
        cast(2'd1, 1'b0);
        cast(2'd2, 1'b0);
        cast(2'd3, 1'b0);
        cnt = 0;
`endif
        repeat (2) tick();

        // New session from DONE, all no
        pulse_start();
        expect_result("all_no", 3'b001, 4'b0000, 4'b1111);
        cast(2'd0, 1'b0);
        cast(2'd1, 1'b0);
        cast(2'd2, 1'b0);
        cast(2'd3, 1'b0);
        repeat (3) tick();

        check("result_queue_drained", 32'(exp_q.size()), 32'd0);
        check("dup_queue_drained", 32'(dup_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
